alu_sweep_driver: RTL and testbench

Sequential initiator for the 4-bit combinational ALU. It latches one operand pair and drives the ALU's operand and select inputs through all eight opcodes in turn. After a settle interval it captures each 8-bit result and streams it out over a valid/ready interface. It sits between a command source and the ALU so an operand pair can be characterised automatically, on silicon or in simulation.

---
 rtl/alu_sweep_driver_if.sv | 32 +++
 rtl/alu_sweep_driver.sv | 184 ++++++++++++++++++
 tb/tb_alu_sweep_driver.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/alu_sweep_driver_if.sv
// Bundle between alu_sweep_driver and its surroundings: command source,
// ALU operand/opcode/result lines and the result stream.
// master = the sweep driver, slave = the command source / ALU / consumer side.
interface alu_sweep_driver_if;
    logic       start;
    logic [3:0] op_a;
    logic [3:0] op_b;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [2:0] alu_s;
    logic [7:0] alu_y;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_data;
    logic [2:0] res_sel;
    logic       busy;
    logic       done;
    logic       err;
    logic [3:0] err_cnt;

    modport master (
        input  start, op_a, op_b, alu_y, res_ready,
        output alu_a, alu_b, alu_s, res_valid, res_data, res_sel,
               busy, done, err, err_cnt
    );

    modport slave (
        output start, op_a, op_b, alu_y, res_ready,
        input  alu_a, alu_b, alu_s, res_valid, res_data, res_sel,
               busy, done, err, err_cnt
    );
endinterface

// File: rtl/alu_sweep_driver.sv
// Sweep driver for the 4-bit combinational ALU: latches one operand pair,
// steps alu_s through opcodes 0..7, waits SETTLE_CYCLES edges per opcode,
// captures alu_y and hands each result out over valid/ready.
// Optional macro ALU_CHECK_EN: adds a reference model that compares every
// captured result and reports mismatches on err / err_cnt.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start; outputs hold last values (busy=0)
// SETTLE  | opcode on alu_s, counting down until alu_y is sampled
// OUT     | result presented on res_*, waiting for the handshake
module alu_sweep_driver #(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    alu_sweep_driver_if.master bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_OUT    = 2'd2
    } state_t;

    localparam logic [3:0] LP_SETTLE = 4'(SETTLE_CYCLES);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [3:0] r_cnt;
    logic [3:0] r_alu_a;
    logic [3:0] r_alu_b;
    logic [2:0] r_alu_s;
    logic       r_res_valid;
    logic [7:0] r_res_data;
    logic [2:0] r_res_sel;
    logic       r_busy;
    logic       r_done;

    logic       w_accept;
    logic       w_capture;
    logic       w_handshake;
    logic       w_last;

    assign w_last = (r_alu_s == 3'd7);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and datapath strobes
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_capture   = 1'b0;
        w_handshake = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                // a count of 1 means this edge is the last settle edge
                if (r_cnt <= 4'd1) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_OUT;
                end
            end
            ST_OUT: begin
                if (r_res_valid && bus.res_ready) begin
                    w_handshake = 1'b1;
                    w_state_nxt = w_last ? ST_IDLE : ST_SETTLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Operand/opcode drive, settle counter, result capture and status
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= 4'd0;
            r_alu_a     <= 4'd0;
            r_alu_b     <= 4'd0;
            r_alu_s     <= 3'd0;
            r_res_valid <= 1'b0;
            r_res_data  <= 8'd0;
            r_res_sel   <= 3'd0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_alu_a <= bus.op_a;
                r_alu_b <= bus.op_b;
                r_alu_s <= 3'd0;
                r_cnt   <= LP_SETTLE;
                r_busy  <= 1'b1;
            end
            if (r_state == ST_SETTLE && !w_capture) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_capture) begin
                r_res_data  <= bus.alu_y;
                r_res_sel   <= r_alu_s;
                r_res_valid <= 1'b1;
            end
            if (w_handshake) begin
                r_res_valid <= 1'b0;
                if (w_last) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end else begin
                    r_alu_s <= r_alu_s + 3'd1;
                    r_cnt   <= LP_SETTLE;
                end
            end
        end
    end

`ifdef ALU_CHECK_EN
    logic       r_err;
    logic [3:0] r_err_cnt;
    logic [7:0] w_ref_y;

    // Expected ALU result for the opcode currently driven; widths follow
    // the ALU: zero-extended arithmetic/logic, 8-bit two's complement sub
    always_comb begin
        w_ref_y = 8'd0;
        case (r_alu_s)
            3'd0: w_ref_y = {4'd0, r_alu_a} + {4'd0, r_alu_b};
            3'd1: w_ref_y = {4'd0, r_alu_a} - {4'd0, r_alu_b};
            3'd2: w_ref_y = {4'd0, r_alu_a & r_alu_b};
            3'd3: w_ref_y = {4'd0, r_alu_a | r_alu_b};
            3'd4: w_ref_y = {4'd0, r_alu_a} * {4'd0, r_alu_b};
            3'd5: w_ref_y = {4'd0, r_alu_a};
            3'd6: w_ref_y = {4'd0, r_alu_b};
            3'd7: w_ref_y = {4'd0, r_alu_a ^ r_alu_b};
            default: w_ref_y = 8'd0;
        endcase
    end

    // Sticky mismatch flag and saturating mismatch counter, cleared by start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err     <= 1'b0;
            r_err_cnt <= 4'd0;
        end else if (w_accept) begin
            r_err     <= 1'b0;
            r_err_cnt <= 4'd0;
        end else if (w_capture && (bus.alu_y != w_ref_y)) begin
            r_err <= 1'b1;
            if (r_err_cnt != 4'hF) begin
                r_err_cnt <= r_err_cnt + 4'd1;
            end
        end
    end

    assign bus.err     = r_err;
    assign bus.err_cnt = r_err_cnt;
`else
    assign bus.err     = 1'b0;
    assign bus.err_cnt = 4'd0;
`endif

    assign bus.alu_a     = r_alu_a;
    assign bus.alu_b     = r_alu_b;
    assign bus.alu_s     = r_alu_s;
    assign bus.res_valid = r_res_valid;
    assign bus.res_data  = r_res_data;
    assign bus.res_sel   = r_res_sel;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;

endmodule

// File: tb/tb_alu_sweep_driver.sv
// Randomised self-checking bench for alu_sweep_driver with a behavioural
// ALU (optionally faulty on opcode 4) and a result-list reference model.
module tb_alu_sweep_driver;

    localparam int S = 1;

`ifdef ALU_CHECK_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    alu_sweep_driver_if bus();

    alu_sweep_driver #(.SETTLE_CYCLES(S)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    bit         fault;
    int         n_chk;
    int         n_err;
    logic [7:0] got [8];

    function automatic int ref_res(input int a, input int b, input int op);
        case (op)
            0: return a + b;
            1: return (a - b) & 255;
            2: return a & b;
            3: return a | b;
            4: return a * b;
            5: return a;
            6: return b;
            default: return a ^ b;
        endcase
    endfunction

    // ALU under characterisation
    assign bus.alu_y = (fault && bus.alu_s == 3'd4) ? 8'h00
                     : 8'(ref_res(int'(bus.alu_a), int'(bus.alu_b), int'(bus.alu_s)));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    // One sweep, started at a negedge; returns at a negedge.
    task automatic run_sweep(input logic [3:0] a, input logic [3:0] b,
                             input int stall_op, input int stall_len,
                             input bit rnd, input bit b2b);
        logic [7:0] exp_r [8];
        int e, n, stalls, st;
        bit hs;
        for (int i = 0; i < 8; i++) exp_r[i] = 8'(ref_res(int'(a), int'(b), i));
        if (fault) exp_r[4] = 8'h00;
        bus.op_a  = a;
        bus.op_b  = b;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("alu_a_latch", bus.alu_a, a);
        chk("alu_b_latch", bus.alu_b, b);
        chk("alu_s_first", bus.alu_s, 0);
        chk("busy_rise", bus.busy, 1);
        chk("done_low", bus.done, 0);
        chk("err_clr", bus.err, 0);
        chk("err_cnt_clr", bus.err_cnt, 0);
        e = 0; n = 0; stalls = 0; st = 0;
        while (n < 8 && e < 400) begin
            bus.op_a  = 4'($urandom);
            bus.op_b  = 4'($urandom);
            bus.start = (e == 2);
            if (bus.res_valid && int'(bus.res_sel) == stall_op && st < stall_len) begin
                bus.res_ready = 1'b0;
                st++;
                chk("stall_data", bus.res_data, exp_r[stall_op]);
                chk("stall_alu_s", bus.alu_s, stall_op);
                chk("stall_valid", bus.res_valid, 1);
            end else if (rnd) begin
                bus.res_ready = ($urandom_range(0, 2) != 0);
            end else begin
                bus.res_ready = 1'b1;
            end
            hs = bus.res_valid && bus.res_ready;
            if (bus.res_valid && !bus.res_ready) stalls++;
            if (hs) begin
                chk("res_data", bus.res_data, exp_r[n]);
                chk("res_sel", bus.res_sel, n);
                got[n] = bus.res_data;
            end
            @(negedge clk);
            e++;
            if (hs) n++;
        end
        bus.start = 1'b0;
        chk("result_count", n, 8);
        chk("done_pulse", bus.done, 1);
        chk("busy_fall", bus.busy, 0);
        chk("valid_clr", bus.res_valid, 0);
        chk("sweep_len", e, 8 * (S + 1) + stalls);
        chk("err_flag", bus.err, (fault && CHK_EN) ? 1 : 0);
        chk("err_count", bus.err_cnt, (fault && CHK_EN) ? 1 : 0);
        if (!b2b) begin
            @(negedge clk);
            chk("done_one_cycle", bus.done, 0);
        end
    endtask

    initial begin
        int k;
        n_chk = 0;
        n_err = 0;
        fault = 1'b0;
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.op_a = 4'd0;
        bus.op_b = 4'd0;
        bus.res_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_alu_a", bus.alu_a, 0);
        chk("rst_alu_s", bus.alu_s, 0);
        chk("rst_valid", bus.res_valid, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // basic sweep against the fixed table
        run_sweep(4'hD, 4'h9, -1, 0, 1'b0, 1'b0);
        chk("tbl0", got[0], 8'h16); chk("tbl1", got[1], 8'h04);
        chk("tbl2", got[2], 8'h09); chk("tbl3", got[3], 8'h0D);
        chk("tbl4", got[4], 8'h75); chk("tbl5", got[5], 8'h0D);
        chk("tbl6", got[6], 8'h09); chk("tbl7", got[7], 8'h04);

        run_sweep(4'h9, 4'hD, -1, 0, 1'b0, 1'b0);
        chk("neg_sub", got[1], 8'hFC);
        run_sweep(4'hF, 4'hF, -1, 0, 1'b0, 1'b0);
        chk("full_mul", got[4], 8'hE1);
        chk("full_add", got[0], 8'h1E);

        // backpressure on opcode 2
        run_sweep(4'hD, 4'h9, 2, 5, 1'b0, 1'b0);

        // back-to-back sweeps
        run_sweep(4'h3, 4'h5, -1, 0, 1'b0, 1'b1);
        run_sweep(4'hA, 4'h6, -1, 0, 1'b0, 1'b0);

        // faulty ALU on opcode 4, then a clean sweep clears the status
        fault = 1'b1;
        run_sweep(4'h7, 4'h4, -1, 0, 1'b0, 1'b0);
        fault = 1'b0;
        run_sweep(4'h2, 4'h3, -1, 0, 1'b0, 1'b0);

        // reset in the middle of a sweep
        bus.op_a = 4'h5;
        bus.op_b = 4'hC;
        bus.start = 1'b1;
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        k = 0;
        while (bus.alu_s != 3'd3 && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("rst_reach_op3", bus.alu_s, 3);
        rst_n = 1'b0;
        #1;
        chk("arst_alu_a", bus.alu_a, 0);
        chk("arst_alu_b", bus.alu_b, 0);
        chk("arst_alu_s", bus.alu_s, 0);
        chk("arst_valid", bus.res_valid, 0);
        chk("arst_data", bus.res_data, 0);
        chk("arst_sel", bus.res_sel, 0);
        chk("arst_busy", bus.busy, 0);
        chk("arst_done", bus.done, 0);
        chk("arst_err", bus.err, 0);
        chk("arst_err_cnt", bus.err_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_sweep(4'h5, 4'hC, -1, 0, 1'b0, 1'b0);

        // randomised sweeps with random backpressure
        for (int i = 0; i < 20; i++) begin
            run_sweep(4'($urandom), 4'($urandom), int'($urandom_range(0, 7)),
                      int'($urandom_range(0, 3)), 1'b1, (i != 19) && $urandom_range(0, 1) == 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
